// File: rtl/mst_arbiter_pkg.sv
// Shared definitions for the Master FIFO arbiter: TLP word fields, command codes and FSM states.
package mst_arbiter_pkg;

  localparam int SOP_BIT = 17;
  localparam int EOP_BIT = 16;
  localparam int CMD_MSB = 17;
  localparam int CMD_LSB = 14;

  localparam logic [3:0] CMD_WR = 4'b1010;
  localparam logic [3:0] CMD_RD = 4'b1000;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_XFER  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  function automatic logic is_wr_hdr(input logic [17:0] w);
    return w[CMD_MSB:CMD_LSB] == CMD_WR;
  endfunction

  function automatic logic is_rd_hdr(input logic [17:0] w);
    return w[CMD_MSB:CMD_LSB] == CMD_RD;
  endfunction

endpackage

// File: rtl/mst_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_i (wrapping), one-hot plus index.
module mst_arbiter_rr_pick #(
  parameter int NPORT = 2,
  parameter int PW    = 1
) (
  input  logic [NPORT-1:0] req_i,
  input  logic [PW-1:0]    last_i,
  output logic [NPORT-1:0] gnt_o,
  output logic [PW-1:0]    idx_o,
  output logic             any_o
);

  always_comb begin
    logic [PW-1:0] p;
    p     = '0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= NPORT; k++) begin
      p = PW'((int'(last_i) + k) % NPORT);
      if (!any_o && req_i[p]) begin
        any_o    = 1'b1;
        gnt_o[p] = 1'b1;
        idx_o    = p;
      end
    end
  end

endmodule

// File: rtl/mst_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared Master FIFO from NPORT staging FIFOs.
// Optional per-port TLP counters are built when ARB_STATS_EN is defined; otherwise pkt_cnt is 0.
//   state     | meaning
//   ARB_IDLE  | no owner; pick next requester after rr pointer
//   ARB_XFER  | popping and forwarding the owner's TLP until its EOP word arrives
//   ARB_DRAIN | EOP seen; flush hold register, then release grant
module mst_arbiter
  import mst_arbiter_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int DW    = 18
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NPORT*DW-1:0] req_dout,
  input  logic [NPORT-1:0]    req_empty,
  output logic [NPORT-1:0]    req_rd_en,
  output logic [DW-1:0]       mst_din,
  output logic                mst_wr_en,
  input  logic                mst_full,
  output logic [NPORT-1:0]    grant,
  output logic                proto_err,
  output logic [NPORT*16-1:0] pkt_cnt
);

  localparam int PW = (NPORT > 2) ? 2 : 1;

  arb_state_e       state_q, state_d;
  logic [NPORT-1:0] grant_q, grant_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic             inflight_q, inflight_d;
  logic             hold_v_q, hold_v_d;
  logic [DW-1:0]    hold_q, hold_d;
  logic             eop_seen_q, eop_seen_d;
  logic             first_q, first_d;
  logic             proto_err_q, proto_err_d;

  logic [NPORT-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic [DW-1:0]    cur_word;

  mst_arbiter_rr_pick #(.NPORT(NPORT), .PW(PW)) u_pick (
    .req_i  (~req_empty),
    .last_i (rr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign cur_word  = req_dout[int'(gidx_q)*DW +: DW];
  assign grant     = grant_q;
  assign proto_err = proto_err_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_q        <= PW'(NPORT-1);
      inflight_q  <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_q      <= '0;
      eop_seen_q  <= 1'b0;
      first_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_q        <= rr_d;
      inflight_q  <= inflight_d;
      hold_v_q    <= hold_v_d;
      hold_q      <= hold_d;
      eop_seen_q  <= eop_seen_d;
      first_q     <= first_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    inflight_d  = 1'b0;
    hold_v_d    = hold_v_q;
    hold_d      = hold_q;
    eop_seen_d  = eop_seen_q;
    first_d     = first_q;
    proto_err_d = proto_err_q;
    req_rd_en   = '0;
    mst_wr_en   = 1'b0;
    mst_din     = '0;

    // A parked word always goes out before anything newly popped.
    if (hold_v_q) begin
      if (!mst_full) begin
        mst_wr_en = 1'b1;
        mst_din   = hold_q;
        hold_v_d  = 1'b0;
      end
    end else if (inflight_q) begin
      if (!mst_full) begin
        mst_wr_en = 1'b1;
        mst_din   = cur_word;
      end else begin
        hold_d   = cur_word;
        hold_v_d = 1'b1;
      end
    end

    // SOP must appear exactly on the first word of a grant; either violation is flagged and forwarded.
    if (inflight_q) begin
      if (first_q != cur_word[SOP_BIT]) proto_err_d = 1'b1;
      first_d = 1'b0;
      if (cur_word[EOP_BIT]) eop_seen_d = 1'b1;
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_gnt;
          gidx_d     = pick_idx;
          first_d    = 1'b1;
          eop_seen_d = 1'b0;
          state_d    = ARB_XFER;
        end
      end
      ARB_XFER: begin
        inflight_d = !req_empty[gidx_q] && !mst_full && !hold_v_q && !eop_seen_q
                     && !(inflight_q && cur_word[EOP_BIT]);
        req_rd_en[gidx_q] = inflight_d;
        if (inflight_q && cur_word[EOP_BIT]) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!inflight_q && !hold_v_q) begin
          rr_d       = gidx_q;
          grant_d    = '0;
          eop_seen_d = 1'b0;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

`ifdef ARB_STATS_EN
  logic [15:0] cnt_q [NPORT];
  logic        wr_eop;

  assign wr_eop = mst_wr_en & mst_din[EOP_BIT];

  for (genvar i = 0; i < NPORT; i++) begin : g_cnt
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) cnt_q[i] <= '0;
      else if (wr_eop && gidx_q == PW'(i)) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
    assign pkt_cnt[i*16 +: 16] = cnt_q[i];
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_mst_arbiter.sv
// Directed bench for mst_arbiter: staging FIFO and Master FIFO models, one task per scenario.
module tb_mst_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [35:0] req_dout;
  logic [1:0]  req_empty;
  logic [1:0]  req_rd_en;
  logic [17:0] mst_din;
  logic        mst_wr_en;
  logic        mst_full;
  logic [1:0]  grant;
  logic        proto_err;
  logic [31:0] pkt_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [17:0] smem [0:1][0:63];
  int          wp [0:1];
  int          rp [0:1];
  logic [17:0] dout_r [0:1];
  logic [17:0] omem [0:511];
  int          op = 0;
  int          mon_err = 0;
  logic        full_man = 1'b0;
  logic        pulse_mode = 1'b0;
  logic        rd_d = 1'b0;

  always #5 sys_clk = ~sys_clk;

  assign req_dout     = {dout_r[1], dout_r[0]};
  assign req_empty[0] = (wp[0] == rp[0]);
  assign req_empty[1] = (wp[1] == rp[1]);
  assign mst_full     = full_man | (pulse_mode & rd_d);

  mst_arbiter #(.NPORT(2), .DW(18)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_dout  (req_dout),
    .req_empty (req_empty),
    .req_rd_en (req_rd_en),
    .mst_din   (mst_din),
    .mst_wr_en (mst_wr_en),
    .mst_full  (mst_full),
    .grant     (grant),
    .proto_err (proto_err),
    .pkt_cnt   (pkt_cnt)
  );

  // Staging FIFO pops, Master FIFO capture, and protocol monitors
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rp[0] <= 0;
      rp[1] <= 0;
      rd_d  <= 1'b0;
    end else begin
      rd_d <= |req_rd_en;
      for (int i = 0; i < 2; i++) begin
        if (req_rd_en[i]) begin
          if (wp[i] == rp[i]) mon_err <= mon_err + 1;
          dout_r[i] <= smem[i][rp[i] & 63];
          rp[i]     <= rp[i] + 1;
        end
      end
      if (mst_wr_en) begin
        if (mst_full) mon_err <= mon_err + 1;
        omem[op & 511] <= mst_din;
        op <= op + 1;
      end
    end
  end

  initial begin
    wp[0] = 0; wp[1] = 0;
    dout_r[0] = '0; dout_r[1] = '0;
  end

  task automatic push(input int p, input logic [17:0] w);
    smem[p][wp[p] & 63] = w;
    wp[p] = wp[p] + 1;
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    full_man = 1'b0;
    pulse_mode = 1'b0;
    #1;
    wp[0] = 0; wp[1] = 0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_words(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (op >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_grant(input logic [1:0] g, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (grant == g) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    tests_run++;
    if (req_rd_en !== 2'b00 || mst_wr_en !== 1'b0 || mst_din !== 18'h0) begin
      tests_failed++;
      $display("FAIL reset_fifo_ports: rd_en=%b wr_en=%b din=%h, need 0/0/0", req_rd_en, mst_wr_en, mst_din);
    end
    tests_run++;
    if (grant !== 2'b00 || proto_err !== 1'b0 || pkt_cnt !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_status: grant=%b err=%b cnt=%h, need 00/0/0", grant, proto_err, pkt_cnt);
    end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    tests_run++;
    if (grant !== 2'b00 || req_rd_en !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_no_req: grant=%b rd_en=%b, need 00/00", grant, req_rd_en);
    end
  endtask

  task automatic test_single();
    logic [17:0] w [4];
    bit ok;
    int base;
    w[0] = 18'h28011; w[1] = 18'h00022; w[2] = 18'h00033; w[3] = 18'h10044;
    @(negedge sys_clk);
    base = op;
    for (int k = 0; k < 4; k++) push(0, w[k]);
    wait_grant(2'b01, 10, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL single_grant: grant=%b, need 01", grant); end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mst_wr_en === 1'b1) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (mst_wr_en !== 1'b1 || mst_din !== w[k]) begin
        tests_failed++;
        $display("FAIL single_word%0d: wr_en=%b din=%h, need 1/%h", k, mst_wr_en, mst_din, w[k]);
      end
      @(negedge sys_clk);
    end
    tests_run++;
    if (mst_wr_en !== 1'b0) begin tests_failed++; $display("FAIL single_stop: wr_en=%b, need 0", mst_wr_en); end
    @(negedge sys_clk);
    tests_run++;
    if (grant !== 2'b00 || op - base != 4) begin
      tests_failed++;
      $display("FAIL single_release: grant=%b words=%0d, need 00/4", grant, op - base);
    end
  endtask

  task automatic test_round_robin();
    logic [17:0] exp [18];
    bit ok;
    int base, n;
    apply_reset();
    base = op;
    n = 0;
    for (int t = 0; t < 3; t++)
      for (int p = 0; p < 2; p++) begin
        logic [17:0] tag;
        tag = 18'(p * 16 + t * 4);
        exp[n]   = 18'h28000 | tag;
        exp[n+1] = tag | 18'h1;
        exp[n+2] = 18'h10000 | tag | 18'h2;
        n += 3;
      end
    for (int i = 0; i < 18; i++) push((i / 3) % 2, exp[i]);
    wait_words(base + 18, 200, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL rr_timeout: words=%0d, need 18", op - base); end
    for (int i = 0; i < 18; i++) begin
      tests_run++;
      if (omem[(base + i) & 511] !== exp[i]) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: got %h, need %h", i, omem[(base + i) & 511], exp[i]);
      end
    end
  endtask

  task automatic test_full_pulse();
    logic [17:0] exp [16];
    bit ok;
    int base, err0;
    @(negedge sys_clk);
    base = op;
    err0 = mon_err;
    pulse_mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp[k] = (k == 0) ? 18'h28000 : (k == 15) ? 18'h1000F : 18'(k);
      push(0, exp[k]);
    end
    wait_words(base + 16, 300, ok);
    repeat (5) @(negedge sys_clk);
    pulse_mode = 1'b0;
    tests_run++;
    if (ok !== 1'b1 || op - base != 16) begin
      tests_failed++;
      $display("FAIL full_count: words=%0d, need 16", op - base);
    end
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (omem[(base + k) & 511] !== exp[k]) begin
        tests_failed++;
        $display("FAIL full_word[%0d]: got %h, need %h", k, omem[(base + k) & 511], exp[k]);
      end
    end
    tests_run++;
    if (mon_err != err0) begin
      tests_failed++;
      $display("FAIL full_protocol: monitor errors=%0d, need 0", mon_err - err0);
    end
  endtask

  task automatic test_stall_mid_packet();
    logic [17:0] exp [8];
    bit ok;
    int base;
    exp[0] = 18'h28020; exp[1] = 18'h00021; exp[2] = 18'h00022;
    exp[3] = 18'h00023; exp[4] = 18'h00024; exp[5] = 18'h10025;
    exp[6] = 18'h28030; exp[7] = 18'h10031;
    @(negedge sys_clk);
    base = op;
    push(1, exp[0]); push(1, exp[1]);
    wait_grant(2'b10, 10, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL stall_grant: grant=%b, need 10", grant); end
    push(0, exp[6]); push(0, exp[7]);
    repeat (20) @(negedge sys_clk);
    tests_run++;
    if (grant !== 2'b10 || op - base != 2 || req_rd_en[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_hold: grant=%b words=%0d rd0=%b, need 10/2/0", grant, op - base, req_rd_en[0]);
    end
    for (int k = 2; k < 6; k++) push(1, exp[k]);
    wait_words(base + 8, 60, ok);
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (omem[(base + k) & 511] !== exp[k]) begin
        tests_failed++;
        $display("FAIL stall_order[%0d]: got %h, need %h", k, omem[(base + k) & 511], exp[k]);
      end
    end
  endtask

  task automatic test_proto_err();
    bit ok;
    int base;
    apply_reset();
    base = op;
    push(0, 18'h00011); push(0, 18'h10022);
    wait_words(base + 2, 20, ok);
    @(negedge sys_clk);
    tests_run++;
    if (ok !== 1'b1 || proto_err !== 1'b1 || omem[base & 511] !== 18'h00011) begin
      tests_failed++;
      $display("FAIL proto_nosop: err=%b word=%h, need 1/00011", proto_err, omem[base & 511]);
    end
    push(0, 18'h28033); push(0, 18'h10044);
    wait_words(base + 4, 20, ok);
    repeat (2) @(negedge sys_clk);
    tests_run++;
    if (ok !== 1'b1 || proto_err !== 1'b1 || omem[(base + 3) & 511] !== 18'h10044) begin
      tests_failed++;
      $display("FAIL proto_sticky: err=%b word=%h, need 1/10044", proto_err, omem[(base + 3) & 511]);
    end
    push(0, 18'h28050);
    for (int k = 1; k < 5; k++) push(0, 18'(18'h50 + k));
    push(0, 18'h10055);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (mst_wr_en === 1'b1) begin ok = 1'b1; break; end
    end
    sys_rst_n = 1'b0;
    #1;
    tests_run++;
    if (ok !== 1'b1 || grant !== 2'b00 || req_rd_en !== 2'b00 || mst_wr_en !== 1'b0
        || mst_din !== 18'h0 || proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midpkt_reset: seen_wr=%b grant=%b rd=%b wr=%b din=%h err=%b, need 1/00/00/0/0/0",
               ok, grant, req_rd_en, mst_wr_en, mst_din, proto_err);
    end
    wp[0] = 0; wp[1] = 0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_stats();
    bit ok;
    int base;
    logic [31:0] exp_cnt;
    apply_reset();
    base = op;
    for (int k = 0; k < 5; k++) push(0, 18'(18'h30000 + k));
    for (int k = 0; k < 2; k++) push(1, 18'(18'h30010 + k));
    wait_words(base + 7, 100, ok);
    repeat (3) @(negedge sys_clk);
`ifdef ARB_STATS_EN
    exp_cnt = {16'd2, 16'd5};
`else
    exp_cnt = 32'h0;
`endif
    tests_run++;
    if (ok !== 1'b1 || pkt_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL stats_cnt: pkt_cnt=%h words=%0d, need %h/7", pkt_cnt, op - base, exp_cnt);
    end
    tests_run++;
    if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL stats_single_word_legal: err=%b, need 0", proto_err); end
    tests_run++;
    if (mon_err != 0) begin tests_failed++; $display("FAIL monitor_total: errors=%0d, need 0", mon_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_pulse();
    test_stall_mid_packet();
    test_proto_err();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule
